ap_ctrl_hs_driver: RTL and testbench
====================================

Name: ap_ctrl_hs_driver

Overview:
- Synthesizable initiator for the ap_ctrl_hs block-level handshake. It drives ap_start/ap_continue into an HLS core (for example the cordiccart2pol top) and consumes that core's ap_ready/ap_done.
- Issues a programmed number of transactions, with up to MAX_OUTSTANDING of them overlapped.
- Timestamps each accepted start and reports per-transaction latency (last, min, max).
- It is the active counterpart of the passive module-status monitor, and is used for on-board and RTL bring-up of the same core.

Parameters:
- CNT_W, 16, width of the transaction count and the issued/completed counters.
- LAT_W, 32, width of the free-running cycle counter and all latency values.
- MAX_OUTSTANDING, 4, depth of the timestamp FIFO and the cap on in-flight transactions; power of two, ≥1.
- TIMEOUT, 100000, idle cycles with work outstanding and no ap_done before aborting.

Ports:
- clock in 1 rising-edge clock.
- reset in 1 asynchronous, active-high reset.
- cmd_go in 1 one-cycle pulse; starts a run when in IDLE, ignored otherwise.
- cmd_count in CNT_W number of transactions; sampled on an accepted cmd_go.
- stall in 1 backpressure request for ap_continue (see Optional Feature).
- ap_ready in 1 from core: start accepted.
- ap_done in 1 from core: one transaction finished.
- ap_start out 1 to core.
- ap_continue out 1 to core.
- busy out 1 high in RUN and DRAIN.
- run_done out 1 one-cycle pulse on entry to IDLE from DRAIN or ABORT.
- timeout_err out 1 sticky; cleared on the next accepted cmd_go.
- proto_err out 1 sticky; set by ap_done with zero outstanding, or by ap_ready while ap_start=0. Cleared on the next accepted cmd_go.
- issued out CNT_W starts accepted this run.
- completed out CNT_W dones counted this run.
- lat_last out LAT_W latency of the most recent completion.
- lat_min out LAT_W minimum latency this run.
- lat_max out LAT_W maximum latency this run.

Behaviour:
- Reset values: state IDLE; all outputs 0; lat_min all-ones; FIFO empty; cycle counter 0.
- Cycle counter: free-running; increments every cycle; wraps modulo 2^LAT_W.
- States: IDLE, RUN, DRAIN, ABORT.
- IDLE, cmd_go=1:
  - If cmd_count=0: pulse run_done next cycle; stay IDLE; counters are still cleared.
  - Else: clear issued, completed, lat_* and errors; latch the count; go to RUN.
- ap_start (registered) = 1 in RUN when issued < count and outstanding < MAX_OUTSTANDING; else 0.
- Accept: ap_start && ap_ready. Increments issued and pushes the current cycle counter into the FIFO.
- Completion: ap_done && ap_continue with outstanding > 0.
  - Pops the FIFO; completed increments.
  - lat_last = now − popped timestamp, modulo 2^LAT_W (a back-to-back accept/done in adjacent cycles gives 1).
  - lat_min and lat_max update in the same cycle as lat_last.
- Simultaneous accept and completion in one cycle: push and pop both happen; outstanding is unchanged. If the FIFO is full, the pop frees the slot for the push in that same cycle.
- ap_done with outstanding = 0: set proto_err; nothing is popped; completed does not change.
- RUN → DRAIN when issued reaches count. The transition happens on the accept edge, and ap_start drops in the same registered cycle.
- DRAIN → IDLE (run_done pulse) when completed reaches count.
- Timeout counter:
  - Counts cycles with outstanding > 0 and no completion; resets on each completion.
  - On reaching TIMEOUT in RUN or DRAIN: set timeout_err and go to ABORT.
- ABORT: ap_start=0; flush the FIFO; go to IDLE next cycle with a run_done pulse.
- busy: 1 in RUN and DRAIN; 0 in IDLE and ABORT.
- Reset mid-run: immediate return to reset values. Any outstanding core work is abandoned.

Optional Feature:
- Macro: AP_CONTINUE_EN.
- With the macro defined: ap_continue = ~stall, registered. ap_done is counted only while ap_continue=1; the core holds ap_done until then.
- Without the macro: ap_continue is tied to 1 and stall is ignored. The port is still present.

Test Plan:
- cmd_go, cmd_count=3; core asserts ap_ready the cycle after ap_start and ap_done 10 cycles after each accept → issued=completed=3; lat_last=lat_min=lat_max=10; one run_done pulse; errors 0.
- Pipelined core (ready every cycle, done 5 cycles after accept) with MAX_OUTSTANDING=4, count=8 → ap_start deasserts after 4 accepts until the first done; all latencies 5; completed=8.
- Done and ready in the same cycle with the FIFO full → outstanding stays 4; no lost or duplicated timestamp; final completed equals count.
- ap_done pulsed in IDLE → proto_err=1; completed=0. A following cmd_go clears proto_err.
- Core never asserts ap_done, TIMEOUT=50 → timeout_err after 50 idle cycles, then ABORT, IDLE and run_done; busy=0.
- With AP_CONTINUE_EN: hold stall=1 for 7 cycles while the core holds ap_done → no completion counted while stalled; counted once after release; latency includes the 7 stall cycles.

Source files
------------

// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs block-level handshake: issues N starts, tracks per-transaction latency.
// Build option AP_CONTINUE_EN: drive ap_continue from ~stall instead of tying it high.
module ap_ctrl_hs_driver #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned LAT_W           = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_go,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             stall,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_start,
    output logic             ap_continue,
    output logic             busy,
    output logic             run_done,
    output logic             timeout_err,
    output logic             proto_err,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] completed,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LAT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] completed_q, completed_d;
    logic [LAT_W-1:0] lat_last_q, lat_last_d;
    logic [LAT_W-1:0] lat_min_q, lat_min_d;
    logic [LAT_W-1:0] lat_max_q, lat_max_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LAT_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [LAT_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ap_start_q, ap_start_d;
    logic             busy_q, busy_d;
    logic             run_done_q, run_done_d;
    logic             timeout_err_q, timeout_err_d;
    logic             proto_err_q, proto_err_d;

    logic             cont;
    logic             push;
    logic             pop;
    logic             bad_done;
    logic             bad_ready;
    logic             tmo_hit;
    logic [LAT_W-1:0] lat_now;

`ifdef AP_CONTINUE_EN
    logic ap_continue_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ap_continue_q <= 1'b0;
        end else begin
            ap_continue_q <= ~stall;
        end
    end

    assign cont = ap_continue_q;
`else
    // stall has no effect in this build; the port stays for a uniform pinout.
    logic unused_stall;
    assign unused_stall = stall;
    assign cont         = 1'b1;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Completion is only legal with work outstanding; ABORT discards whatever is left.
    assign push      = ap_start_q && ap_ready;
    assign pop       = ap_done && cont && (occ_q != '0) && (state_q != S_ABORT);
    assign bad_done  = ap_done && cont && (occ_q == '0);
    assign bad_ready = ap_ready && !ap_start_q;
    assign lat_now   = cyc_q - fifo_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q + LAT_W'(1);
        count_d       = count_q;
        issued_d      = issued_q;
        completed_d   = completed_q;
        lat_last_d    = lat_last_q;
        lat_min_d     = lat_min_q;
        lat_max_d     = lat_max_q;
        occ_d         = occ_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_d        = fifo_q;
        tmo_d         = tmo_q;
        timeout_err_d = timeout_err_q;
        proto_err_d   = proto_err_q;
        run_done_d    = 1'b0;
        tmo_hit       = 1'b0;

        if (push) begin
            fifo_d[wr_ptr_q] = cyc_q;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            issued_d         = issued_q + CNT_W'(1);
        end

        if (pop) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            completed_d = completed_q + CNT_W'(1);
            lat_last_d  = lat_now;
            if (lat_now < lat_min_q) begin
                lat_min_d = lat_now;
            end
            if (lat_now > lat_max_q) begin
                lat_max_d = lat_now;
            end
        end

        // A simultaneous push and pop leave occupancy unchanged, even when full.
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        if (pop || (occ_q == '0)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        tmo_hit = (tmo_d == TMO_W'(TIMEOUT));

        if (bad_done || bad_ready) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_go) begin
                    count_d       = cmd_count;
                    issued_d      = '0;
                    completed_d   = '0;
                    lat_last_d    = '0;
                    lat_min_d     = '1;
                    lat_max_d     = '0;
                    timeout_err_d = 1'b0;
                    proto_err_d   = 1'b0;
                    if (cmd_count == '0) begin
                        run_done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (tmo_hit) begin
                    state_d       = S_ABORT;
                    timeout_err_d = 1'b1;
                end else if (issued_d == count_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tmo_hit) begin
                    state_d       = S_ABORT;
                    timeout_err_d = 1'b1;
                end else if (completed_d == count_q) begin
                    state_d    = S_IDLE;
                    run_done_d = 1'b1;
                end
            end
            S_ABORT: begin
                state_d    = S_IDLE;
                run_done_d = 1'b1;
                occ_d      = '0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                tmo_d      = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Evaluated on next-state values so ap_start drops on the final or capping accept edge.
        ap_start_d = (state_d == S_RUN) && (issued_d < count_d)
                     && (occ_d < OCC_W'(MAX_OUTSTANDING));
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cyc_q         <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            lat_last_q    <= '0;
            lat_min_q     <= '1;
            lat_max_q     <= '0;
            occ_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tmo_q         <= '0;
            ap_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            completed_q   <= completed_d;
            lat_last_q    <= lat_last_d;
            lat_min_q     <= lat_min_d;
            lat_max_q     <= lat_max_d;
            occ_q         <= occ_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tmo_q         <= tmo_d;
            ap_start_q    <= ap_start_d;
            busy_q        <= busy_d;
            run_done_q    <= run_done_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
            fifo_q        <= fifo_d;
        end
    end

`ifdef AP_CONTINUE_EN
    assign ap_continue = ap_continue_q;
`else
    assign ap_continue = 1'b1;
`endif
    assign ap_start    = ap_start_q;
    assign busy        = busy_q;
    assign run_done    = run_done_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;
    assign issued      = issued_q;
    assign completed   = completed_q;
    assign lat_last    = lat_last_q;
    assign lat_min     = lat_min_q;
    assign lat_max     = lat_max_q;

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Directed bench for ap_ctrl_hs_driver with a behavioural ap_ctrl_hs core model.
module tb_ap_ctrl_hs_driver;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT_W = 32;
    localparam int unsigned MAXO  = 4;
    localparam int unsigned TMO   = 50;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_go;
    logic [CNT_W-1:0] cmd_count;
    logic             stall;
    logic             ap_ready = 1'b0;
    logic             ap_done  = 1'b0;
    logic             ap_start;
    logic             ap_continue;
    logic             busy;
    logic             run_done;
    logic             timeout_err;
    logic             proto_err;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] completed;
    logic [LAT_W-1:0] lat_last;
    logic [LAT_W-1:0] lat_min;
    logic [LAT_W-1:0] lat_max;

    ap_ctrl_hs_driver #(
        .CNT_W          (CNT_W),
        .LAT_W          (LAT_W),
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT        (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_go     (cmd_go),
        .cmd_count  (cmd_count),
        .stall      (stall),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_start   (ap_start),
        .ap_continue(ap_continue),
        .busy       (busy),
        .run_done   (run_done),
        .timeout_err(timeout_err),
        .proto_err  (proto_err),
        .issued     (issued),
        .completed  (completed),
        .lat_last   (lat_last),
        .lat_min    (lat_min),
        .lat_max    (lat_max)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Core model knobs and state
    int ready_lat  = 0;
    int done_lat   = 1;
    bit never_done = 1'b0;
    bit spur_done  = 1'b0;
    bit spur_ready = 1'b0;
    int wait_cnt   = 0;
    int tcyc       = 0;
    int rd_pulses  = 0;
    bit st_prev    = 1'b0;
    bit cont_prev  = 1'b0;
    int due_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Core behaviour, evaluated mid-cycle: ready after ready_lat waiting cycles, done done_lat after accept.
    task automatic core_step();
        tcyc++;
        if (st_prev && ap_ready) begin
            wait_cnt = 0;
            due_q.push_back(tcyc - 1 + done_lat);
        end else if (st_prev) begin
            wait_cnt++;
        end
        if (ap_done && cont_prev && (due_q.size() > 0)) begin
            void'(due_q.pop_front());
        end
        if (run_done) begin
            rd_pulses++;
        end
        st_prev   = ap_start;
        cont_prev = ap_continue;
        ap_ready  = spur_ready || (ap_start && (wait_cnt >= ready_lat));
        ap_done   = spur_done || (!never_done && (due_q.size() > 0) && (due_q[0] <= tcyc));
    endtask

    task automatic model_reset();
        due_q.delete();
        wait_cnt = 0;
    endtask

    task automatic go(input int cnt);
        @(posedge clock);
        #2;
        cmd_count = CNT_W'(cnt);
        cmd_go    = 1'b1;
        @(posedge clock);
        #2;
        cmd_go    = 1'b0;
    endtask

    task automatic wait_run_done(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (run_done) break;
        end
        check("run_done_seen", 64'(run_done), 64'd1);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            core_step();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        cmd_go    = 1'b0;
        cmd_count = '0;
        stall     = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ap_start", 64'(ap_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(run_done), 64'd0);
        check("rst_issued", 64'(issued), 64'd0);
        check("rst_completed", 64'(completed), 64'd0);
        check("rst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
        check("rst_lat_max", 64'(lat_max), 64'd0);
        check("rst_errs", 64'({timeout_err, proto_err}), 64'd0);
        #1 reset = 1'b0;

        // Ready one cycle after start, done 10 after accept
        ready_lat = 1;
        done_lat  = 10;
        rd_pulses = 0;
        go(3);
        wait_run_done(n);
        check("t1_cycles", 64'(n), 64'd16);
        repeat (3) @(posedge clock);
        #1;
        check("t1_issued", 64'(issued), 64'd3);
        check("t1_completed", 64'(completed), 64'd3);
        check("t1_lat_last", 64'(lat_last), 64'd10);
        check("t1_lat_min", 64'(lat_min), 64'd10);
        check("t1_lat_max", 64'(lat_max), 64'd10);
        check("t1_pulses", 64'(rd_pulses), 64'd1);
        check("t1_errs", 64'({timeout_err, proto_err}), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // Pipelined core caps at MAX_OUTSTANDING in flight
        ready_lat = 0;
        done_lat  = 5;
        go(8);
        repeat (4) @(posedge clock);
        #1;
        check("t2_start_capped", 64'(ap_start), 64'd0);
        check("t2_issued_cap", 64'(issued), 64'd4);
        check("t2_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        check("t2_start_resume", 64'(ap_start), 64'd1);
        wait_run_done(n);
        check("t2_completed", 64'(completed), 64'd8);
        check("t2_issued", 64'(issued), 64'd8);
        check("t2_lat_min", 64'(lat_min), 64'd5);
        check("t2_lat_max", 64'(lat_max), 64'd5);

        // Steady state with done and ready landing in the same cycle
        done_lat = 4;
        go(8);
        wait_run_done(n);
        check("t3_completed", 64'(completed), 64'd8);
        check("t3_lat_min", 64'(lat_min), 64'd4);
        check("t3_lat_max", 64'(lat_max), 64'd4);
        check("t3_proto", 64'(proto_err), 64'd0);

        // Zero-count go clears counters and pulses run_done
        go(0);
        check("t4_run_done", 64'(run_done), 64'd1);
        check("t4_completed", 64'(completed), 64'd0);
        check("t4_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
        check("t4_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        check("t4_run_done_off", 64'(run_done), 64'd0);

        // Spurious done in IDLE
        @(posedge clock);
        #2 spur_done = 1'b1;
        @(posedge clock);
        #2 spur_done = 1'b0;
        check("t5_proto_done", 64'(proto_err), 64'd1);
        check("t5_completed", 64'(completed), 64'd0);
        done_lat = 2;
        go(1);
        check("t5_proto_clr", 64'(proto_err), 64'd0);
        wait_run_done(n);
        check("t5_completed1", 64'(completed), 64'd1);
        check("t5_lat_last", 64'(lat_last), 64'd2);

        // Spurious ready while ap_start is low
        @(posedge clock);
        #2 spur_ready = 1'b1;
        @(posedge clock);
        #2 spur_ready = 1'b0;
        check("t5_proto_ready", 64'(proto_err), 64'd1);

        // Core never completes: timeout, ABORT, then back to IDLE
        never_done = 1'b1;
        go(1);
        wait_run_done(n);
        check("t6_cycles", 64'(n), 64'd52);
        check("t6_timeout", 64'(timeout_err), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_completed", 64'(completed), 64'd0);
        check("t6_proto", 64'(proto_err), 64'd0);
        model_reset();
        never_done = 1'b0;
        done_lat   = 3;
        go(2);
        wait_run_done(n);
        check("t6_recover_cnt", 64'(completed), 64'd2);
        check("t6_recover_min", 64'(lat_min), 64'd3);
        check("t6_recover_max", 64'(lat_max), 64'd3);
        check("t6_timeout_clr", 64'(timeout_err), 64'd0);

`ifdef AP_CONTINUE_EN
        // Held done is counted only once ap_continue returns
        done_lat = 3;
        go(1);
        @(posedge clock);
        #2;
        @(posedge clock);
        #2 stall = 1'b1;
        repeat (7) @(posedge clock);
        #2 stall = 1'b0;
        check("t7_stall_cnt", 64'(completed), 64'd0);
        check("t7_done_held", 64'(ap_done), 64'd1);
        check("t7_cont_low", 64'(ap_continue), 64'd0);
        wait_run_done(n);
        check("t7_completed", 64'(completed), 64'd1);
        check("t7_lat_last", 64'(lat_last), 64'd10);
`else
        // stall is ignored and ap_continue stays high
        stall    = 1'b1;
        done_lat = 3;
        go(1);
        check("t7_cont_high", 64'(ap_continue), 64'd1);
        wait_run_done(n);
        check("t7_completed", 64'(completed), 64'd1);
        check("t7_lat_last", 64'(lat_last), 64'd3);
        stall = 1'b0;
`endif

        // Reset in the middle of a run
        done_lat = 20;
        go(3);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t8_busy", 64'(busy), 64'd0);
        check("t8_issued", 64'(issued), 64'd0);
        check("t8_ap_start", 64'(ap_start), 64'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        model_reset();
        done_lat = 2;
        go(1);
        wait_run_done(n);
        check("t8_after_cnt", 64'(completed), 64'd1);
        check("t8_after_lat", 64'(lat_last), 64'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
